// File: rtl/lfsr_pkg.sv
// ---------------------------------------------------------------------------
// lfsr_pkg
//  Shared definitions for the LFSR pattern generator / PRBS checker pair.
//  Contents:
//    state_t         checker FSM encoding (ST_SEED, ST_VERIFY, ST_LOCKED)
//    DEFAULT_TAPS_8  Fibonacci mask for x^8+x^6+x^5+x^4+1
//    lfsr_fb()       feedback parity, used by both sides so they agree
// ---------------------------------------------------------------------------
package lfsr_pkg;

  typedef enum logic [1:0] {
    ST_SEED   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2,
    ST_RSVD   = 2'd3
  } state_t;

  localparam logic [7:0] DEFAULT_TAPS_8 = 8'hB8;

  // Widest LFSR the shared feedback function supports; narrower registers
  // are zero-extended by the caller.
  localparam int unsigned LFSR_MAX_W = 32;

  function automatic logic lfsr_fb(input logic [LFSR_MAX_W-1:0] sr,
                                   input logic [LFSR_MAX_W-1:0] taps);
    return ^(sr & taps);
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// ---------------------------------------------------------------------------
// lfsr_step
//  Combinational single step of a Fibonacci LFSR.
//  Ports:
//    sr      in   WIDTH  current register
//    taps    in   WIDTH  feedback mask, bit i = stage i
//    b       in   1      bit to shift in
//    pred    out  1      feedback prediction ^(sr & taps)
//    sr_next out  WIDTH  {sr[WIDTH-2:0], b}
// ---------------------------------------------------------------------------
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] sr,
  input  logic [WIDTH-1:0] taps,
  input  logic             b,
  output logic             pred,
  output logic [WIDTH-1:0] sr_next
);

  always_comb begin
    pred    = lfsr_fb(LFSR_MAX_W'(sr), LFSR_MAX_W'(taps));
    sr_next = {sr[WIDTH-2:0], b};
  end

endmodule

// File: rtl/lfsr_prbs_checker.sv
// ---------------------------------------------------------------------------
// lfsr_prbs_checker
//  Self-synchronising PRBS receiver. Fills its LFSR from the incoming stream,
//  verifies LOCK_CNT consecutive predictions, then free-runs (flywheel) and
//  counts mismatches. Too many errors in one WINDOW drops lock and reseeds.
//  Ports:
//    clk        in   1      rising-edge clock
//    rst        in   1      synchronous active-high reset
//    en         in   1      block enable (low freezes all state)
//    bit_in     in   1      received PRBS bit
//    bit_valid  in   1      bit_in sampled this cycle
//    clr_cnt    in   1      clear err_count (level)
//    locked     out  1      checker in LOCKED
//    err_pulse  out  1      one-cycle pulse per counted mismatch
//    err_count  out  CNT_W  saturating mismatch count while locked
//    state_o    out  2      FSM state (debug)
// ---------------------------------------------------------------------------
module lfsr_prbs_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH      = 8,
  parameter logic [WIDTH-1:0] TAPS       = DEFAULT_TAPS_8,
  parameter int unsigned      LOCK_CNT   = 16,
  parameter int unsigned      WINDOW     = 64,
  parameter int unsigned      UNLOCK_ERR = 4,
  parameter int unsigned      CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [1:0]       state_o
);

  localparam int unsigned FILL_W  = $clog2(WIDTH + 1);
  localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned WIN_W   = $clog2(WINDOW + 1);
  localparam int unsigned WERR_W  = $clog2(UNLOCK_ERR + 1);

  localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(WIDTH - 1);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
  localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(WINDOW - 1);
  localparam logic [WERR_W-1:0]  WERR_LIM   = WERR_W'(UNLOCK_ERR);

  state_t             state, state_n;
  logic [WIDTH-1:0]   sr, sr_n, sr_next;
  logic [FILL_W-1:0]  fill, fill_n;
  logic [MATCH_W-1:0] match, match_n;
  logic [WIN_W-1:0]   window, window_n;
  logic [WERR_W-1:0]  win_err, win_err_n, win_err_inc;
  logic               bit_ev, pred, shift_b, mism, err_hit;

  assign bit_ev = en & bit_valid;

  // Once locked the register is fed its own prediction, so a corrupted
  // received bit is counted once and never propagates into later predictions.
  assign shift_b = (state == ST_LOCKED) ? pred : bit_in;

  lfsr_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .sr      (sr),
    .taps    (TAPS),
    .b       (shift_b),
    .pred    (pred),
    .sr_next (sr_next)
  );

  assign mism        = (bit_in != pred);
  assign win_err_inc = win_err + WERR_W'(mism);

  always_comb begin
    state_n   = state;
    sr_n      = sr;
    fill_n    = fill;
    match_n   = match;
    window_n  = window;
    win_err_n = win_err;
    err_hit   = 1'b0;

    case (state)
      ST_SEED: begin
        if (bit_ev) begin
          sr_n = sr_next;
          if (fill == FILL_LAST) begin
            fill_n = '0;
            if (sr_next != '0) begin
              state_n = ST_VERIFY;
              match_n = '0;
            end
          end else begin
            fill_n = fill + FILL_W'(1);
          end
        end
      end

      ST_VERIFY: begin
        if (bit_ev) begin
          sr_n = sr_next;
          if (mism) begin
            state_n = ST_SEED;
            fill_n  = '0;
            match_n = '0;
          end else if (match == MATCH_LAST) begin
            state_n   = ST_LOCKED;
            match_n   = '0;
            window_n  = '0;
            win_err_n = '0;
          end else begin
            match_n = match + MATCH_W'(1);
          end
        end
      end

      ST_LOCKED: begin
        if (bit_ev) begin
          sr_n    = sr_next;
          err_hit = mism;
          // Unlock is tested before window roll-over so it wins on the same bit.
          if (win_err_inc == WERR_LIM) begin
            state_n   = ST_SEED;
            fill_n    = '0;
            window_n  = '0;
            win_err_n = '0;
          end else if (window == WIN_LAST) begin
            window_n  = '0;
            win_err_n = '0;
          end else begin
            window_n  = window + WIN_W'(1);
            win_err_n = win_err_inc;
          end
        end
      end

      default: begin
        state_n   = ST_SEED;
        fill_n    = '0;
        match_n   = '0;
        window_n  = '0;
        win_err_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_SEED;
      sr        <= '0;
      fill      <= '0;
      match     <= '0;
      window    <= '0;
      win_err   <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_n;
      sr        <= sr_n;
      fill      <= fill_n;
      match     <= match_n;
      window    <= window_n;
      win_err   <= win_err_n;
      locked    <= (state_n == ST_LOCKED);
      err_pulse <= err_hit;
      // A clear that lands on a counted error keeps that error.
      if (clr_cnt) begin
        err_count <= err_hit ? CNT_W'(1) : '0;
      end else if (err_hit && (err_count != '1)) begin
        err_count <= err_count + CNT_W'(1);
      end
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_lfsr_prbs_checker.sv
module tb_lfsr_prbs_checker;

  logic        clk = 1'b0;
  logic        rst, en, bit_in, bit_valid, clr_cnt;
  logic        a_locked, a_pulse, b_locked, b_pulse;
  logic [15:0] a_count;
  logic [3:0]  b_count;
  logic [1:0]  a_state, b_state;

  logic [7:0]  g;
  int          total = 0;
  int          fails = 0;
  int          seen;

  always #5 clk = ~clk;

  lfsr_prbs_checker #(
    .WIDTH      (8),
    .TAPS       (8'hB8),
    .LOCK_CNT   (16),
    .WINDOW     (64),
    .UNLOCK_ERR (4),
    .CNT_W      (16)
  ) dut_a (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .clr_cnt   (clr_cnt),
    .locked    (a_locked),
    .err_pulse (a_pulse),
    .err_count (a_count),
    .state_o   (a_state)
  );

  lfsr_prbs_checker #(
    .WIDTH      (8),
    .TAPS       (8'hB8),
    .LOCK_CNT   (16),
    .WINDOW     (64),
    .UNLOCK_ERR (4),
    .CNT_W      (4)
  ) dut_b (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .clr_cnt   (clr_cnt),
    .locked    (b_locked),
    .err_pulse (b_pulse),
    .err_count (b_count),
    .state_o   (b_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference generator: x^8+x^6+x^5+x^4+1 Fibonacci, output bit = feedback.
  task automatic next_bit(output logic b);
    b = ^(g & 8'hB8);
    g = {g[6:0], b};
  endtask

  task automatic send(input logic b);
    en        = 1'b1;
    bit_valid = 1'b1;
    bit_in    = b;
    tick();
    bit_valid = 1'b0;
  endtask

  task automatic send_clean(input int n);
    logic b;
    for (int i = 0; i < n; i++) begin
      next_bit(b);
      send(b);
    end
  endtask

  task automatic send_err();
    logic b;
    next_bit(b);
    send(~b);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; en = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; clr_cnt = 1'b0;
    g = 8'h01;
    tick(); tick();
    chk("rst_locked", a_locked, 0);
    chk("rst_pulse", a_pulse, 0);
    chk("rst_count", a_count, 0);
    chk("rst_state", a_state, 0);
    rst = 1'b0;

    // Lock on clean stream from seed 01.
    send_clean(23);
    chk("pre_lock_locked", a_locked, 0);
    chk("pre_lock_state", a_state, 1);
    send_clean(1);
    chk("lock_locked", a_locked, 1);
    chk("lock_state", a_state, 2);
    chk("lock_count", a_count, 0);

    // Single error.
    send_err();
    chk("err1_pulse", a_pulse, 1);
    chk("err1_count", a_count, 1);
    chk("err1_locked", a_locked, 1);
    send_clean(1);
    chk("err1_pulse_drop", a_pulse, 0);
    chk("err1_count_hold", a_count, 1);
    send_clean(5);
    chk("err1_flywheel_count", a_count, 1);
    chk("err1_flywheel_locked", a_locked, 1);
    send_clean(57);   // completes the 64-bit window

    // Clear while disabled.
    en = 1'b0; clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
    chk("clr_en_low_count", a_count, 0);
    chk("clr_en_low_locked", a_locked, 1);

    // Four errors in one window drop lock.
    send_err(); send_clean(2);
    send_err(); send_clean(1);
    send_err();
    chk("three_err_locked", a_locked, 1);
    send_clean(1);
    send_err();
    chk("unlock_locked", a_locked, 0);
    chk("unlock_state", a_state, 0);
    chk("unlock_count", a_count, 4);
    chk("unlock_pulse", a_pulse, 1);

    // Relock, then three errors at the end of a window and one in the next.
    send_clean(23);
    chk("relock_pre_state", a_state, 1);
    send_clean(1);
    chk("relock_locked", a_locked, 1);
    send_clean(61);
    send_err(); send_err(); send_err();
    chk("win_edge_locked", a_locked, 1);
    send_err();
    chk("win_next_locked", a_locked, 1);
    chk("win_next_count", a_count, 8);
    send_clean(1);

    // en low with valid bits: everything held.
    en = 1'b0; bit_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bit_in = i[0];
      tick();
    end
    bit_valid = 1'b0;
    chk("hold_locked", a_locked, 1);
    chk("hold_pulse", a_pulse, 0);
    chk("hold_count", a_count, 8);
    chk("hold_state", a_state, 2);
    send_clean(1);
    chk("hold_resume_pulse", a_pulse, 0);
    chk("hold_resume_count", a_count, 8);
    en = 1'b1; bit_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bit_in = ~i[0];
      tick();
    end
    send_clean(1);
    chk("novalid_resume_pulse", a_pulse, 0);
    chk("novalid_resume_locked", a_locked, 1);

    // Saturation on the 4-bit counter.
    en = 1'b0; clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
    chk("sat_clr_b", b_count, 0);
    for (int i = 0; i < 16; i++) begin
      send_err();
      send_clean(64);
    end
    chk("sat_b_count", b_count, 15);
    chk("sat_a_count", a_count, 16);
    chk("sat_b_locked", b_locked, 1);

    // Clear coincident with a counted error keeps that error.
    clr_cnt = 1'b1;
    send_err();
    clr_cnt = 1'b0;
    chk("clr_coinc_a", a_count, 1);
    chk("clr_coinc_b", b_count, 1);
    chk("clr_coinc_pulse", a_pulse, 1);
    send_clean(1);
    chk("clr_coinc_after", a_count, 1);

    // Reset while locked.
    rst = 1'b1; en = 1'b0; tick(); rst = 1'b0;
    chk("rst_mid_locked", a_locked, 0);
    chk("rst_mid_state", a_state, 0);
    chk("rst_mid_count", a_count, 0);
    chk("rst_mid_pulse", a_pulse, 0);

    // All-zero stream never leaves SEED.
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      send(1'b0);
      if (a_locked || (a_state != 2'd0)) seen++;
    end
    chk("zeros_never_lock", seen, 0);
    chk("zeros_state", a_state, 0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
